// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer: command sequencer between the calc register slave and the
// arithmetic datapath. Accepts one operation per command handshake, runs it
// (ADD/SUB immediately, MUL shift-add and DIV/MOD restoring over DATA_WIDTH
// cycles) and holds the result on a valid/ready response port.
// Optional feature macro: CALC_OVF_DETECT_EN (reports status 11 on ADD carry,
// SUB borrow, or a nonzero upper product half for MUL).
module calc_op_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_a,
    input  logic [DATA_WIDTH-1:0] cmd_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic [1:0]            rsp_status,
    output logic                  busy
);

    localparam int W = DATA_WIDTH;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_MOD = 3'd4;

    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_DIV0 = 2'b01;
    localparam logic [1:0] ST_ILL  = 2'b10;
`ifdef CALC_OVF_DETECT_EN
    localparam logic [1:0] ST_OVF  = 2'b11;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           op_q, op_d;
    logic [W-1:0]         a_q, a_d;
    logic [W-1:0]         b_q, b_d;
    logic [2*W-1:0]       acc_q, acc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [W-1:0]         rsp_result_q, rsp_result_d;
    logic [1:0]           rsp_status_q, rsp_status_d;

    // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV/MOD
    logic [W:0]           mul_sum;
    logic [W:0]           div_shift;
    logic [W:0]           div_diff;
    logic [W-1:0]         fin_result;
    logic [1:0]           fin_status;
`ifdef CALC_OVF_DETECT_EN
    logic [W:0]           add_wide;
`endif

    // State register; reset aborts any operation in flight
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state: iterative ops with a usable divisor go through EXEC, everything else straight to RESP
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if ((cmd_op == OP_MUL) ||
                        (((cmd_op == OP_DIV) || (cmd_op == OP_MOD)) && (cmd_b != '0)))
                        state_d = EXEC;
                    else
                        state_d = RESP;
                end
            end
            EXEC: if (cnt_q == CNT_WIDTH'(W - 1)) state_d = RESP;
            RESP: if (rsp_valid_q && rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        cmd_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
    end

    // Final result and status from the latched operands and the iteration accumulator
    always_comb begin
        fin_result = '0;
        fin_status = ST_OK;
`ifdef CALC_OVF_DETECT_EN
        add_wide = {1'b0, a_q} + {1'b0, b_q};
`endif
        case (op_q)
            OP_ADD: begin
                fin_result = a_q + b_q;
`ifdef CALC_OVF_DETECT_EN
                if (add_wide[W]) fin_status = ST_OVF;
`endif
            end
            OP_SUB: begin
                fin_result = a_q - b_q;
`ifdef CALC_OVF_DETECT_EN
                if (a_q < b_q) fin_status = ST_OVF;
`endif
            end
            OP_MUL: begin
                fin_result = acc_q[W-1:0];
`ifdef CALC_OVF_DETECT_EN
                if (acc_q[2*W-1:W] != '0) fin_status = ST_OVF;
`endif
            end
            OP_DIV: begin
                if (b_q == '0) begin
                    fin_result = '1;
                    fin_status = ST_DIV0;
                end else begin
                    fin_result = acc_q[W-1:0];
                end
            end
            OP_MOD: begin
                if (b_q == '0) begin
                    fin_result = a_q;
                    fin_status = ST_DIV0;
                end else begin
                    fin_result = acc_q[2*W-1:W];
                end
            end
            default: begin
                fin_result = '0;
                fin_status = ST_ILL;
            end
        endcase
    end

    // Datapath next values: latch command, iterate one bit per cycle, then load the response once
    always_comb begin
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_status_d = rsp_status_q;
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_q} : '0);
        div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
        div_diff  = div_shift - {1'b0, b_q};
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d  = cmd_op;
                    a_d   = cmd_a;
                    b_d   = cmd_b;
                    cnt_d = '0;
                    acc_d = {{W{1'b0}}, (cmd_op == OP_MUL) ? cmd_b : cmd_a};
                end
            end
            EXEC: begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
                if (op_q == OP_MUL)
                    acc_d = {mul_sum, acc_q[W-1:1]};
                else if (!div_diff[W])
                    acc_d = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
                else
                    acc_d = {div_shift[W-1:0], acc_q[W-2:0], 1'b0};
            end
            RESP: begin
                if (!rsp_valid_q) begin
                    rsp_valid_d  = 1'b1;
                    rsp_result_d = fin_result;
                    rsp_status_d = fin_status;
                end else if (rsp_ready) begin
                    rsp_valid_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath and response registers, all cleared by reset
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_status_q <= ST_OK;
        end else begin
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_status_q <= rsp_status_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_status = rsp_status_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// tb_calc_op_sequencer: directed and randomized checks of calc_op_sequencer
// against an arithmetic reference model (results, status codes, latency).
module tb_calc_op_sequencer;

    localparam int W = 32;

    logic         ACLK = 1'b0;
    logic         ARESETN;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_result;
    logic [1:0]   rsp_status;
    logic         busy;

    int errors = 0;
    int checks = 0;

    calc_op_sequencer #(.DATA_WIDTH(W), .CNT_WIDTH(6)) dut (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_status (rsp_status),
        .busy       (busy)
    );

    always #5 ACLK = ~ACLK;

    // Reference: plain arithmetic on the operands, latency in edges after the accept edge
    task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] res, output logic [1:0] st, output int lat);
        logic [2*W-1:0] prod;
        prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        st  = 2'b00;
        lat = 1;
        case (op)
            3'd0: begin
                res = a + b;
`ifdef CALC_OVF_DETECT_EN
                if (res < a) st = 2'b11;
`endif
            end
            3'd1: begin
                res = a - b;
`ifdef CALC_OVF_DETECT_EN
                if (a < b) st = 2'b11;
`endif
            end
            3'd2: begin
                res = prod[W-1:0];
                lat = W + 1;
`ifdef CALC_OVF_DETECT_EN
                if (prod[2*W-1:W] != 0) st = 2'b11;
`endif
            end
            3'd3: begin
                if (b == 0) begin res = '1; st = 2'b01; end
                else begin res = a / b; lat = W + 1; end
            end
            3'd4: begin
                if (b == 0) begin res = a; st = 2'b01; end
                else begin res = a % b; lat = W + 1; end
            end
            default: begin res = '0; st = 2'b10; end
        endcase
    endtask

    // Present one command, then wait (bounded) for rsp_valid; lat = -1 on timeout
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] res, output logic [1:0] st, output int lat);
        @(negedge ACLK);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        @(posedge ACLK);
        #1;
        cmd_valid = 1'b0;
        lat = 0;
        while (rsp_valid !== 1'b1) begin
            if (lat > 200) begin
                lat = -1;
                break;
            end
            @(posedge ACLK);
            #1;
            lat++;
        end
        res = rsp_result;
        st  = rsp_status;
    endtask

    task automatic test_reset();
        ARESETN   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_a     = '0;
        cmd_b     = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_cmd_ready: got %0b expected 1", cmd_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %0b expected 0", rsp_valid); end
        checks++; if (rsp_result !== '0) begin errors++; $display("[TB] FAIL reset_rsp_result: got %0h expected 0", rsp_result); end
        checks++; if (rsp_status !== 2'b00) begin errors++; $display("[TB] FAIL reset_rsp_status: got %0b expected 00", rsp_status); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
        @(negedge ACLK);
        ARESETN = 1'b1;
    endtask

    task automatic test_directed();
        logic [2:0]   ops [9]  = '{3'd0, 3'd3, 3'd4, 3'd3, 3'd4, 3'd2, 3'd2, 3'd2, 3'd3};
        logic [W-1:0] as [9]   = '{32'd5, 32'd100, 32'd100, 32'h1234, 32'h1234, 32'h00010000, 32'd3, 32'd0, 32'd3};
        logic [W-1:0] bs [9]   = '{32'd7, 32'd7, 32'd7, 32'd0, 32'd0, 32'h00010000, 32'h0000FFFF, 32'd5, 32'd10};
        logic [W-1:0] eres [9] = '{32'd12, 32'd14, 32'd2, 32'hFFFFFFFF, 32'h1234, 32'd0, 32'h0002FFFD, 32'd0, 32'd0};
        logic [1:0]   est [9];
        int           elat [9] = '{1, 33, 33, 1, 1, 33, 33, 33, 33};
        logic [W-1:0] res;
        logic [1:0]   st;
        int           lat;
        est = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
`ifdef CALC_OVF_DETECT_EN
        est[5] = 2'b11;
`endif
        for (int i = 0; i < 9; i++) begin
            issue(ops[i], as[i], bs[i], res, st, lat);
            checks++; if (res !== eres[i]) begin errors++; $display("[TB] FAIL directed%0d_result: got %0h expected %0h", i, res, eres[i]); end
            checks++; if (st !== est[i]) begin errors++; $display("[TB] FAIL directed%0d_status: got %0b expected %0b", i, st, est[i]); end
            checks++; if (lat != elat[i]) begin errors++; $display("[TB] FAIL directed%0d_latency: got %0d expected %0d", i, lat, elat[i]); end
            checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL directed%0d_busy_resp: got %0b expected 1", i, busy); end
            @(posedge ACLK);
            #1;
            checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL directed%0d_ready_after: got %0b expected 1", i, cmd_ready); end
        end
    endtask

    task automatic test_random();
        logic [2:0]   op;
        logic [W-1:0] a, b, res, eres;
        logic [1:0]   st, est;
        int           lat, elat;
        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 255));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 4) == 0) a = W'($urandom_range(0, 300));
            model(op, a, b, eres, est, elat);
            issue(op, a, b, res, st, lat);
            checks++; if (res !== eres) begin errors++; $display("[TB] FAIL rand%0d_result op=%0d a=%0h b=%0h: got %0h expected %0h", i, op, a, b, res, eres); end
            checks++; if (st !== est) begin errors++; $display("[TB] FAIL rand%0d_status op=%0d: got %0b expected %0b", i, op, st, est); end
            checks++; if (lat != elat) begin errors++; $display("[TB] FAIL rand%0d_latency op=%0d: got %0d expected %0d", i, op, lat, elat); end
            @(posedge ACLK);
            #1;
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] res;
        logic [1:0]   st;
        int           lat;
        rsp_ready = 1'b0;
        issue(3'd0, 32'd1, 32'd1, res, st, lat);
        checks++; if (lat != 1) begin errors++; $display("[TB] FAIL bp_latency: got %0d expected 1", lat); end
        for (int k = 0; k < 5; k++) begin
            @(negedge ACLK);
            cmd_valid = (k == 1);
            cmd_op    = 3'd0;
            cmd_a     = 32'd9;
            cmd_b     = 32'd9;
            @(posedge ACLK);
            #1;
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp%0d_valid: got %0b expected 1", k, rsp_valid); end
            checks++; if (rsp_result !== 32'd2) begin errors++; $display("[TB] FAIL bp%0d_result: got %0h expected 2", k, rsp_result); end
            checks++; if (rsp_status !== 2'b00) begin errors++; $display("[TB] FAIL bp%0d_status: got %0b expected 00", k, rsp_status); end
            checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp%0d_cmd_ready: got %0b expected 0", k, cmd_ready); end
            checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL bp%0d_busy: got %0b expected 1", k, busy); end
        end
        @(negedge ACLK);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge ACLK);
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_after: got %0b expected 1", cmd_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_valid_after: got %0b expected 0", rsp_valid); end
        repeat (3) @(posedge ACLK);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL bp_ignored_cmd_busy: got %0b expected 0", busy); end
        issue(3'd0, 32'd2, 32'd3, res, st, lat);
        checks++; if (res !== 32'd5) begin errors++; $display("[TB] FAIL bp_next_result: got %0h expected 5", res); end
        @(posedge ACLK);
        #1;
    endtask

    task automatic test_reset_mid_mul();
        logic [W-1:0] res;
        logic [1:0]   st;
        int           lat;
        int           seen;
        @(negedge ACLK);
        cmd_valid = 1'b1;
        cmd_op    = 3'd2;
        cmd_a     = 32'd12345;
        cmd_b     = 32'd6789;
        @(posedge ACLK);
        #1;
        cmd_valid = 1'b0;
        repeat (10) @(posedge ACLK);
        #3;
        ARESETN = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %0b expected 0", busy); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_cmd_ready: got %0b expected 1", cmd_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_rsp_valid: got %0b expected 0", rsp_valid); end
        checks++; if (rsp_result !== '0) begin errors++; $display("[TB] FAIL abort_rsp_result: got %0h expected 0", rsp_result); end
        checks++; if (rsp_status !== 2'b00) begin errors++; $display("[TB] FAIL abort_rsp_status: got %0b expected 00", rsp_status); end
        @(negedge ACLK);
        ARESETN = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge ACLK);
            #1;
            if (rsp_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("[TB] FAIL abort_no_response: got %0d valid cycles expected 0", seen); end
        issue(3'd1, 32'd9, 32'd4, res, st, lat);
        checks++; if (res !== 32'd5) begin errors++; $display("[TB] FAIL sub_result: got %0h expected 5", res); end
        checks++; if (st !== 2'b00) begin errors++; $display("[TB] FAIL sub_status: got %0b expected 00", st); end
        @(posedge ACLK);
        #1;
        issue(3'd6, 32'd9, 32'd4, res, st, lat);
        checks++; if (res !== '0) begin errors++; $display("[TB] FAIL illegal_result: got %0h expected 0", res); end
        checks++; if (st !== 2'b10) begin errors++; $display("[TB] FAIL illegal_status: got %0b expected 10", st); end
        checks++; if (lat != 1) begin errors++; $display("[TB] FAIL illegal_latency: got %0d expected 1", lat); end
        @(posedge ACLK);
        #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
